// File: rtl/mem_access_stage.sv
// MIPS-32 memory-access stage: issues loads/stores over a req/ack
// handshake, extracts load lanes and registers the write-back payload.
module mem_access_stage #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_load_unsigned,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [31:0]       wb_alu_result,
  output logic [31:0]       wb_load_data,
  output logic              wb_mem_sel,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              wb_misalign
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef struct packed {
    logic [31:0]       alu;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        lane;
    logic [1:0]        size;
    logic              uns;
    logic [4:0]        rd;
    logic              reg_write;
    logic              store;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } acc_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] load;
    logic        mem_sel;
    logic [4:0]  rd;
    logic        reg_write;
    logic        misalign;
  } wb_t;

  state_t      state_q, state_n;
  acc_t        acc_q, acc_n;
  wb_t         wb_q, wb_n;

  logic        is_mem;
  logic        sz_half;
  logic        sz_word;
  logic        misalign;
  logic        start;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] lane_data;
  logic [31:0] load_c;

  assign is_mem  = ex_valid & (ex_mem_read | ex_mem_write);
  assign sz_half = (ex_size == 2'b01);
  assign sz_word = ex_size[1];

  assign misalign = is_mem &
    ((sz_half & ex_alu_result[0]) |
     (sz_word & |ex_alu_result[1:0]));

  assign start = (state_q == IDLE) & is_mem & ~misalign;

  always_comb begin
    be_c    = '0;
    wdata_c = '0;
    unique case (1'b1)
      sz_word: begin
        be_c    = 4'b1111;
        wdata_c = ex_store_data;
      end
      sz_half: begin
        be_c    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b0001 << ex_alu_result[1:0];
        wdata_c = {4{ex_store_data[7:0]}};
      end
    endcase
  end

  // Loads pick the addressed lane; sign bit is masked for LBU/LHU.
  assign lane_data = dmem_rdata >> {acc_q.lane, 3'b000};

  always_comb begin
    load_c = '0;
    unique case (1'b1)
      acc_q.size[1]: load_c = dmem_rdata;
      acc_q.size == 2'b01:
        load_c = {{16{~acc_q.uns & lane_data[15]}},
                  lane_data[15:0]};
      default:
        load_c = {{24{~acc_q.uns & lane_data[7]}},
                  lane_data[7:0]};
    endcase
  end

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n         = ACCESS;
          acc_n.alu       = ex_alu_result;
          acc_n.addr      = {ex_alu_result[ADDR_W-1:2], 2'b00};
          acc_n.lane      = ex_alu_result[1:0];
          acc_n.size      = ex_size;
          acc_n.uns       = ex_load_unsigned;
          acc_n.rd        = ex_rd;
          acc_n.reg_write = ex_reg_write;
          acc_n.store     = ex_mem_write;
          acc_n.wdata     = ex_mem_write ? wdata_c : '0;
          acc_n.be        = be_c;
        end
      end
      ACCESS: begin
        if (dmem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wb_n = '0;
    if (state_q == ACCESS) begin
      if (dmem_ack) begin
        wb_n.valid     = 1'b1;
        wb_n.alu       = acc_q.alu;
        wb_n.load      = acc_q.store ? '0 : load_c;
        wb_n.mem_sel   = ~acc_q.store;
        wb_n.rd        = acc_q.rd;
        wb_n.reg_write = acc_q.reg_write & ~acc_q.store;
      end
    end else if (misalign) begin
      wb_n.valid    = 1'b1;
      wb_n.alu      = ex_alu_result;
      wb_n.rd       = ex_rd;
      wb_n.misalign = 1'b1;
    end else if (!start) begin
      wb_n.valid     = ex_valid;
      wb_n.alu       = ex_alu_result;
      wb_n.rd        = ex_rd;
      wb_n.reg_write = ex_valid & ex_reg_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      wb_q    <= wb_n;
    end
  end

  // rst_n gates stall so a held upstream memory op cannot stall in reset.
  assign stall = rst_n &
    ((state_q == IDLE) ? start : ~dmem_ack);

  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & acc_q.store;
  assign dmem_addr  = dmem_req ? acc_q.addr : RESET_ADDR;
  assign dmem_wdata = dmem_req ? acc_q.wdata : '0;
  assign dmem_be    = dmem_req ? acc_q.be : '0;

  assign wb_valid      = wb_q.valid;
  assign wb_alu_result = wb_q.alu;
  assign wb_load_data  = wb_q.load;
  assign wb_mem_sel    = wb_q.mem_sel;
  assign wb_rd         = wb_q.rd;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_misalign   = wb_q.misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus random bench for mem_access_stage, checked against
// a transaction-level model of the memory stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_load_unsigned;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_load_data;
  logic        wb_mem_sel;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_misalign;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(
    .ADDR_W(32),
    .RESET_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_size(ex_size),
    .ex_load_unsigned(ex_load_unsigned),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .stall(stall),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .wb_valid(wb_valid),
    .wb_alu_result(wb_alu_result),
    .wb_load_data(wb_load_data),
    .wb_mem_sel(wb_mem_sel),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_width(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_misalign(input logic [1:0] size,
                                    input logic [31:0] a);
    return (a % m_width(size)) != 0;
  endfunction

  function automatic logic [31:0] m_be(input logic [1:0] size,
                                       input logic [31:0] a);
    int w = m_width(size);
    int off = a % 4;
    return ((1 << w) - 1) << off;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size,
                                          input logic [31:0] d);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata,
                                         input logic [1:0] size,
                                         input logic [31:0] a,
                                         input bit uns);
    longint v;
    longint lim;
    int w = m_width(size);
    if (w == 4) return rdata;
    lim = longint'(1) << (8 * w);
    v = longint'(rdata) / (longint'(1) << (8 * (a % 4)));
    v = v % lim;
    if (!uns && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  task automatic do_op(input bit rd_, input bit wr_, input bit vld,
                       input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input bit regw,
                       input int waits, input logic [31:0] rdata);
    bit mem;
    bit mis;
    int stalls;
    mem = vld && (rd_ || wr_);
    mis = mem && m_misalign(size, a);
    ex_valid         = vld;
    ex_mem_read      = rd_;
    ex_mem_write     = wr_;
    ex_size          = size;
    ex_load_unsigned = uns;
    ex_alu_result    = a;
    ex_store_data    = d;
    ex_rd            = rd;
    ex_reg_write     = regw;
    dmem_ack         = 1'($urandom % 2);
    dmem_rdata       = $urandom;
    #1;
    if (!mem || mis) begin
      chk("idle_stall", 32'(stall), 0);
      chk("idle_req", 32'(dmem_req), 0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      ex_valid = 1'b0;
      #1;
      chk("wb_valid", 32'(wb_valid), 32'(vld));
      chk("wb_misalign", 32'(wb_misalign), 32'(mis));
      if (vld) begin
        chk("wb_alu", wb_alu_result, a);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_mem_sel", 32'(wb_mem_sel), 0);
        chk("wb_reg_write", 32'(wb_reg_write), mis ? 0 : 32'(regw));
      end
      return;
    end
    stalls = 0;
    chk("start_req", 32'(dmem_req), 0);
    if (stall) stalls++;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      ex_alu_result = $urandom;
      ex_store_data = $urandom;
      ex_size       = 2'($urandom);
      ex_mem_write  = 1'($urandom);
      if (k == waits) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end else begin
        dmem_rdata = $urandom;
      end
      #1;
      chk("acc_req", 32'(dmem_req), 1);
      chk("acc_addr", dmem_addr, a & 32'hFFFF_FFFC);
      chk("acc_we", 32'(dmem_we), 32'(wr_));
      chk("acc_be", 32'(dmem_be), m_be(size, a));
      if (wr_) chk("acc_wdata", dmem_wdata, m_wdata(size, d));
      chk("acc_wb_valid", 32'(wb_valid), 0);
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("stall_cycles", 32'(stalls), 32'(1 + waits));
    chk("req_drop", 32'(dmem_req), 0);
    chk("wb_valid", 32'(wb_valid), 1);
    chk("wb_misalign", 32'(wb_misalign), 0);
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk("wb_alu", wb_alu_result, a);
    chk("wb_mem_sel", 32'(wb_mem_sel), wr_ ? 0 : 1);
    chk("wb_reg_write", 32'(wb_reg_write), wr_ ? 0 : 32'(regw));
    if (!wr_) chk("wb_load", wb_load_data, m_load(rdata, size, a, uns));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 0);
    chk({tag, "_wb_alu"}, wb_alu_result, 0);
    chk({tag, "_wb_load"}, wb_load_data, 0);
    chk({tag, "_wb_sel"}, 32'(wb_mem_sel), 0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 0);
    chk({tag, "_wb_rw"}, 32'(wb_reg_write), 0);
    chk({tag, "_wb_mis"}, 32'(wb_misalign), 0);
    chk({tag, "_req"}, 32'(dmem_req), 0);
    chk({tag, "_we"}, 32'(dmem_we), 0);
    chk({tag, "_be"}, 32'(dmem_be), 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_stall"}, 32'(stall), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_mem_read = 1'b0;
    ex_mem_write = 1'b0;
    ex_size = 2'd0;
    ex_load_unsigned = 1'b0;
    ex_rd = '0;
    ex_reg_write = 1'b0;
    dmem_rdata = '0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_cleared("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDU
    do_op(0, 0, 1, 2'd2, 0, 32'h0000_1234, 0, 5'd5, 1, 0, 0);
    // LB, three wait cycles
    do_op(1, 0, 1, 2'd0, 0, 32'h0000_0103, 0, 5'd7, 1, 3,
          32'h80FF_0000);
    // LHU, ack in first access cycle
    do_op(1, 0, 1, 2'd1, 1, 32'h0000_0202, 0, 5'd9, 1, 0,
          32'h8001_7FFF);
    // SB
    do_op(0, 1, 1, 2'd0, 0, 32'h0000_0041, 32'h0000_00AB, 5'd3, 1, 1,
          0);
    // misaligned LW
    do_op(1, 0, 1, 2'd2, 0, 32'h0000_0006, 0, 5'd4, 1, 0, 0);
    // read and write together act as a store
    do_op(1, 1, 1, 2'd1, 0, 32'h0000_0082, 32'h1234_5678, 5'd6, 1, 2,
          32'hDEAD_BEEF);

    // SW abandoned by reset in its second access cycle
    ex_valid = 1'b1;
    ex_mem_read = 1'b0;
    ex_mem_write = 1'b1;
    ex_size = 2'd2;
    ex_alu_result = 32'h0000_0080;
    ex_store_data = 32'hCAFE_F00D;
    ex_rd = 5'd1;
    ex_reg_write = 1'b1;
    @(posedge clk); #1;
    #1;
    chk("sw_req1", 32'(dmem_req), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_cleared("midrst");
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_wb_valid", 32'(wb_valid), 0);
    chk("late_ack_req", 32'(dmem_req), 0);

    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 4);
      logic [31:0] a = $urandom;
      if ($urandom % 2) a = a & 32'h0000_0FFC | 32'($urandom % 4);
      do_op(kind == 2 || kind == 4, kind == 3 || kind == 4,
            kind != 1, 2'($urandom), 1'($urandom), a, $urandom,
            5'($urandom), 1'($urandom), $urandom_range(0, 3),
            $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
